// File: rtl/lc3b_decode_stage.sv
// LC-3b ID stage: decodes the IF instruction and registers it as the ID/EX latch.
// Optional load-use interlock is enabled by defining LOAD_USE_INTERLOCK_EN.
package lc3b_pkg;

  typedef enum logic [2:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
  } lc3b_aluop;

  typedef enum logic [1:0] {
    pcmux_pc2, pcmux_branch, pcmux_jmp, pcmux_trap
  } lc3b_pcmux_sel;

  typedef struct packed {
    logic [3:0]    opcode;
    lc3b_aluop     aluop;
    lc3b_pcmux_sel pcmux_sel;
    logic          load_pc;
    logic          load_regfile;
    logic          load_cc;
    logic          mem_read;
    logic          mem_write;
    logic          check_rd;
    logic          check_rs;
    logic          check_rt;
    logic [7:0]    trapvect;
  } lc3b_control_word;

  localparam logic [3:0] op_br   = 4'b0000;
  localparam logic [3:0] op_add  = 4'b0001;
  localparam logic [3:0] op_ldb  = 4'b0010;
  localparam logic [3:0] op_stb  = 4'b0011;
  localparam logic [3:0] op_jsr  = 4'b0100;
  localparam logic [3:0] op_and  = 4'b0101;
  localparam logic [3:0] op_ldr  = 4'b0110;
  localparam logic [3:0] op_str  = 4'b0111;
  localparam logic [3:0] op_rti  = 4'b1000;
  localparam logic [3:0] op_not  = 4'b1001;
  localparam logic [3:0] op_ldi  = 4'b1010;
  localparam logic [3:0] op_sti  = 4'b1011;
  localparam logic [3:0] op_jmp  = 4'b1100;
  localparam logic [3:0] op_shf  = 4'b1101;
  localparam logic [3:0] op_lea  = 4'b1110;
  localparam logic [3:0] op_trap = 4'b1111;

endpackage

// Purpose: decode if_ir into control word + register specifiers, bubble on load-use.
// Latency: 1 cycle from acceptance (if_valid && if_ready) to the id_* outputs.
// Backpressure: ex_stall holds the latch and drops if_ready; flush overrides both.
module lc3b_decode_stage
  import lc3b_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [15:0]      if_ir,
  input  logic [15:0]      if_pc,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             if_ready,
  output logic             id_valid,
  output lc3b_control_word id_ctrl,
  output logic [15:0]      id_ir,
  output logic [15:0]      id_pc,
  output logic [2:0]       id_sr1,
  output logic [2:0]       id_sr2,
  output logic [2:0]       id_dest
);

  lc3b_control_word dec;
  logic [3:0] opcode;
  logic [2:0] dec_sr1;
  logic [2:0] dec_sr2;
  logic [2:0] dec_dest;
  logic       interlock;

  assign opcode  = if_ir[15:12];
  assign dec_sr1 = if_ir[8:6];

  // Stores read their data register from the field that is the destination elsewhere.
  assign dec_sr2 = (opcode == op_str || opcode == op_stb || opcode == op_sti) ?
                   if_ir[11:9] : if_ir[2:0];

  assign dec_dest = (opcode == op_jsr || opcode == op_trap) ? 3'd7 : if_ir[11:9];

  always_comb begin
    dec          = '0;
    dec.opcode   = opcode;
    dec.trapvect = if_ir[7:0];
    case (opcode)
      op_add, op_and: begin
        dec.aluop        = (opcode == op_add) ? alu_add : alu_and;
        dec.load_regfile = 1'b1;
        dec.load_cc      = 1'b1;
        dec.check_rd     = 1'b1;
        dec.check_rs     = 1'b1;
        dec.check_rt     = ~if_ir[5];
      end
      op_not: begin
        dec.aluop        = alu_not;
        dec.load_regfile = 1'b1;
        dec.load_cc      = 1'b1;
        dec.check_rd     = 1'b1;
        dec.check_rs     = 1'b1;
      end
      op_shf: begin
        // ir[4] selects direction; ir[5] only matters for right shifts.
        dec.aluop    = !if_ir[4] ? alu_sll : (if_ir[5] ? alu_sra : alu_srl);
        dec.check_rs = 1'b1;
      end
      op_ldr, op_ldb, op_ldi: begin
        dec.mem_read     = 1'b1;
        dec.load_regfile = 1'b1;
        dec.load_cc      = 1'b1;
        dec.check_rs     = 1'b1;
      end
      op_str, op_stb, op_sti: begin
        dec.mem_write = 1'b1;
        dec.check_rs  = 1'b1;
        dec.check_rt  = 1'b1;
      end
      op_br: begin
        if (if_ir[11:9] != 3'b000) begin
          dec.load_pc   = 1'b1;
          dec.pcmux_sel = pcmux_branch;
        end
      end
      op_jmp: begin
        dec.check_rs = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef LOAD_USE_INTERLOCK_EN
  assign interlock = if_valid && id_valid && id_ctrl.mem_read && id_ctrl.load_regfile &&
                     ((dec.check_rs && dec_sr1 == id_dest) ||
                      (dec.check_rt && dec_sr2 == id_dest));
`else
  assign interlock = 1'b0;
`endif

  assign if_ready = flush || (!ex_stall && !interlock);

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_ctrl  <= '0;
      id_ir    <= '0;
      id_pc    <= RESET_PC;
      id_sr1   <= '0;
      id_sr2   <= '0;
      id_dest  <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (ex_stall) begin
      id_valid <= id_valid;
    end else if (interlock) begin
      id_valid <= 1'b0;
      id_ctrl  <= '0;
      id_ir    <= '0;
      id_pc    <= '0;
      id_sr1   <= '0;
      id_sr2   <= '0;
      id_dest  <= '0;
    end else begin
      id_valid <= if_valid;
      id_ctrl  <= if_valid ? dec : '0;
      id_ir    <= if_ir;
      id_pc    <= if_pc;
      id_sr1   <= dec_sr1;
      id_sr2   <= dec_sr2;
      id_dest  <= dec_dest;
    end
  end

endmodule

// File: tb/tb_lc3b_decode_stage.sv
// Directed bench for lc3b_decode_stage: expectations are queued at drive time and
// compared one edge later; interlock expectations follow LOAD_USE_INTERLOCK_EN.
module tb_lc3b_decode_stage;
  import lc3b_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_valid;
  logic [15:0]      if_ir;
  logic [15:0]      if_pc;
  logic             ex_stall;
  logic             flush;
  logic             if_ready;
  logic             id_valid;
  lc3b_control_word id_ctrl;
  logic [15:0]      id_ir;
  logic [15:0]      id_pc;
  logic [2:0]       id_sr1;
  logic [2:0]       id_sr2;
  logic [2:0]       id_dest;

  int errors = 0;
  int total  = 0;

  typedef struct {
    logic             v;
    lc3b_control_word c;
    lc3b_control_word cmask;
    logic             full;
    logic [15:0]      ir;
    logic [15:0]      pc;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       d;
  } exp_t;

  exp_t sb[$];

  lc3b_decode_stage #(.RESET_PC(16'h3000)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_valid),
    .if_ir    (if_ir),
    .if_pc    (if_pc),
    .ex_stall (ex_stall),
    .flush    (flush),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .id_ctrl  (id_ctrl),
    .id_ir    (id_ir),
    .id_pc    (id_pc),
    .id_sr1   (id_sr1),
    .id_sr2   (id_sr2),
    .id_dest  (id_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // flags = {load_pc, load_regfile, load_cc, mem_read, mem_write, check_rd, check_rs, check_rt}
  function automatic lc3b_control_word ctl(input logic [3:0] op, input lc3b_aluop alu,
                                           input lc3b_pcmux_sel pm, input logic [7:0] f,
                                           input logic [7:0] tv);
    lc3b_control_word w;
    w              = '0;
    w.opcode       = op;
    w.aluop        = alu;
    w.pcmux_sel    = pm;
    w.load_pc      = f[7];
    w.load_regfile = f[6];
    w.load_cc      = f[5];
    w.mem_read     = f[4];
    w.mem_write    = f[3];
    w.check_rd     = f[2];
    w.check_rs     = f[1];
    w.check_rt     = f[0];
    w.trapvect     = tv;
    return w;
  endfunction

  function automatic exp_t mk(input logic v, input lc3b_control_word c, input logic [15:0] ir,
                              input logic [15:0] pc, input logic [2:0] s1, input logic [2:0] s2,
                              input logic [2:0] d);
    exp_t e;
    e.v = v; e.c = c; e.cmask = '1; e.full = 1'b1;
    e.ir = ir; e.pc = pc; e.s1 = s1; e.s2 = s2; e.d = d;
    return e;
  endfunction

  function automatic exp_t mkv(input logic v, input lc3b_control_word c,
                               input lc3b_control_word cmask);
    exp_t e;
    e = mk(v, c, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
    e.cmask = cmask;
    e.full  = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%0d expected=1 entries", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".id_valid"}, 32'(id_valid), 32'(e.v));
      chk({tag, ".id_ctrl"}, 32'(id_ctrl & e.cmask), 32'(e.c & e.cmask));
      if (e.full) begin
        chk({tag, ".id_ir"},   32'(id_ir),   32'(e.ir));
        chk({tag, ".id_pc"},   32'(id_pc),   32'(e.pc));
        chk({tag, ".id_sr1"},  32'(id_sr1),  32'(e.s1));
        chk({tag, ".id_sr2"},  32'(id_sr2),  32'(e.s2));
        chk({tag, ".id_dest"}, 32'(id_dest), 32'(e.d));
      end
    end
  endtask

  // Drive one cycle of stimulus, check if_ready, queue the expectation, compare after the edge.
  task automatic step(input string tag, input logic rst, input logic v, input logic [15:0] ir,
                      input logic [15:0] pc, input logic st, input logic fl,
                      input logic exp_rdy, input exp_t e);
    reset    = rst;
    if_valid = v;
    if_ir    = ir;
    if_pc    = pc;
    ex_stall = st;
    flush    = fl;
    #1;
    chk({tag, ".if_ready"}, 32'(if_ready), 32'(exp_rdy));
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  // Instruction that depends on a load currently in ID/EX.
  task automatic load_use(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                          input exp_t e);
`ifdef LOAD_USE_INTERLOCK_EN
    step({tag, ".bubble"}, 1'b0, 1'b1, ir, pc, 1'b0, 1'b0, 1'b0,
         mk(1'b0, '0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0));
`endif
    step(tag, 1'b0, 1'b1, ir, pc, 1'b0, 1'b0, 1'b1, e);
  endtask

  initial begin
    exp_t rst_e, add1, ldr1, ldr2, add2, trap_e, rti_e;

    rst_e  = mk(1'b0, '0, 16'h0000, 16'h3000, 3'd0, 3'd0, 3'd0);
    add1   = mk(1'b1, ctl(4'h1, alu_add, pcmux_pc2, 8'b01100111, 8'h83), 16'h1283, 16'h0002, 3'd2, 3'd3, 3'd1);
    ldr1   = mk(1'b1, ctl(4'h6, alu_add, pcmux_pc2, 8'b01110010, 8'h80), 16'h6280, 16'h0004, 3'd2, 3'd0, 3'd1);
    add2   = mk(1'b1, ctl(4'h1, alu_add, pcmux_pc2, 8'b01100111, 8'h44), 16'h1644, 16'h0006, 3'd1, 3'd4, 3'd3);
    ldr2   = mk(1'b1, ctl(4'h6, alu_add, pcmux_pc2, 8'b01110010, 8'h40), 16'h6240, 16'h000A, 3'd1, 3'd0, 3'd1);
    trap_e = mk(1'b1, ctl(4'hF, alu_add, pcmux_pc2, 8'b00000000, 8'h25), 16'hF025, 16'h0018, 3'd0, 3'd5, 3'd7);
    rti_e  = mk(1'b1, '0, 16'h8000, 16'h001E, 3'd0, 3'd0, 3'd0);
    rti_e.cmask.opcode = 4'h0;

    reset = 1'b1; if_valid = 1'b0; if_ir = '0; if_pc = '0; ex_stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, rst_e);

    step("add_reg", 1'b0, 1'b1, 16'h1283, 16'h0002, 1'b0, 1'b0, 1'b1, add1);
    step("ldr", 1'b0, 1'b1, 16'h6280, 16'h0004, 1'b0, 1'b0, 1'b1, ldr1);
    load_use("add_after_ldr", 16'h1644, 16'h0006, add2);

    ldr1.pc = 16'h0008;
    step("ldr_b2b_1", 1'b0, 1'b1, 16'h6280, 16'h0008, 1'b0, 1'b0, 1'b1, ldr1);
    load_use("ldr_b2b_2", 16'h6240, 16'h000A, ldr2);
    add2.pc = 16'h000C;
    load_use("add_after_b2b", 16'h1644, 16'h000C, add2);

    step("str", 1'b0, 1'b1, 16'h7280, 16'h000E, 1'b0, 1'b0, 1'b1,
         mk(1'b1, ctl(4'h7, alu_add, pcmux_pc2, 8'b00001011, 8'h80), 16'h7280, 16'h000E, 3'd2, 3'd1, 3'd1));
    step("not", 1'b0, 1'b1, 16'h927F, 16'h0010, 1'b0, 1'b0, 1'b1,
         mk(1'b1, ctl(4'h9, alu_not, pcmux_pc2, 8'b01100110, 8'h7F), 16'h927F, 16'h0010, 3'd1, 3'd7, 3'd1));
    step("and_imm", 1'b0, 1'b1, 16'h5262, 16'h0012, 1'b0, 1'b0, 1'b1,
         mk(1'b1, ctl(4'h5, alu_and, pcmux_pc2, 8'b01100110, 8'h62), 16'h5262, 16'h0012, 3'd1, 3'd2, 3'd1));
    step("shf_sra", 1'b0, 1'b1, 16'hD231, 16'h0014, 1'b0, 1'b0, 1'b1,
         mk(1'b1, ctl(4'hD, alu_sra, pcmux_pc2, 8'b00000010, 8'h31), 16'hD231, 16'h0014, 3'd0, 3'd1, 3'd1));
    step("jsr", 1'b0, 1'b1, 16'h4800, 16'h0016, 1'b0, 1'b0, 1'b1,
         mk(1'b1, ctl(4'h4, alu_add, pcmux_pc2, 8'b00000000, 8'h00), 16'h4800, 16'h0016, 3'd0, 3'd0, 3'd7));
    step("trap", 1'b0, 1'b1, 16'hF025, 16'h0018, 1'b0, 1'b0, 1'b1, trap_e);

    step("stall_1", 1'b0, 1'b1, 16'h1283, 16'h0100, 1'b1, 1'b0, 1'b0, trap_e);
    step("stall_2_flush", 1'b0, 1'b1, 16'h6280, 16'h0102, 1'b1, 1'b1, 1'b1, mkv(1'b0, '0, '0));
    step("stall_3", 1'b0, 1'b1, 16'h7280, 16'h0104, 1'b1, 1'b0, 1'b0, mkv(1'b0, '0, '0));

    step("br_nop", 1'b0, 1'b1, 16'h0000, 16'h001A, 1'b0, 1'b0, 1'b1,
         mk(1'b1, '0, 16'h0000, 16'h001A, 3'd0, 3'd0, 3'd0));
    step("br_nzp", 1'b0, 1'b1, 16'h0E05, 16'h001C, 1'b0, 1'b0, 1'b1,
         mk(1'b1, ctl(4'h0, alu_add, pcmux_branch, 8'b10000000, 8'h05), 16'h0E05, 16'h001C, 3'd0, 3'd5, 3'd7));
    step("rti", 1'b0, 1'b1, 16'h8000, 16'h001E, 1'b0, 1'b0, 1'b1, rti_e);

    step("flush_only", 1'b0, 1'b1, 16'h1283, 16'h0020, 1'b0, 1'b1, 1'b1, mkv(1'b0, '0, '0));
    step("if_idle", 1'b0, 1'b0, 16'h1283, 16'h0022, 1'b0, 1'b0, 1'b1, mkv(1'b0, '0, '1));

    add1.pc = 16'h0024;
    step("add_again", 1'b0, 1'b1, 16'h1283, 16'h0024, 1'b0, 1'b0, 1'b1, add1);
    step("reset_mid", 1'b1, 1'b1, 16'h6280, 16'h0026, 1'b0, 1'b0, 1'b1, rst_e);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
